// File: rtl/beat_sequencer_if.sv
// Purpose: bundles the beat_sequencer control inputs and pulse/index outputs.
// Latency: none, wiring only.
// Backpressure: none; the outputs are free-running pulses with no ready signal.
interface beat_sequencer_if #(
    parameter int CNT_W  = 34,
    parameter int BEAT_W = 4,
    parameter int SUB_W  = 3
);
    logic              i_enable;
    logic              i_reload;
    logic              i_sync;
    logic [CNT_W-1:0]  i_period;
    logic [BEAT_W-1:0] i_beats_per_bar;
    logic [SUB_W-1:0]  i_subdiv;
    logic              o_beat;
    logic              o_accent;
    logic              o_sub;
    logic [BEAT_W-1:0] o_beat_idx;
    logic [SUB_W-1:0]  o_sub_idx;
    logic              o_busy;

    // Side that supplies tempo settings and consumes the beat pulses.
    modport master (
        output i_enable, i_reload, i_sync, i_period, i_beats_per_bar, i_subdiv,
        input  o_beat, o_accent, o_sub, o_beat_idx, o_sub_idx, o_busy
    );

    // The sequencer itself.
    modport slave (
        input  i_enable, i_reload, i_sync, i_period, i_beats_per_bar, i_subdiv,
        output o_beat, o_accent, o_sub, o_beat_idx, o_sub_idx, o_busy
    );
endinterface

// File: rtl/beat_sequencer.sv
// Purpose: metronome engine emitting beat, bar-accent and subdivision pulses from a beat period.
// Latency: first beat CNT_W+1 cycles after a start/reload; all outputs registered (1 cycle).
// Backpressure: none; pulses are free-running and cannot be stalled by the consumer.
module beat_sequencer #(
    parameter int CNT_W  = 34,
    parameter int BEAT_W = 4,
    parameter int SUB_W  = 3
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    beat_sequencer_if.slave bus
);
    localparam int DC_W = (CNT_W > 2) ? $clog2(CNT_W) : 1;
    localparam logic [DC_W-1:0] DIV_LAST = DC_W'(CNT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic              en_prev_q,  en_prev_d;
    logic [CNT_W-1:0]  period_l_q, period_l_d;
    logic [BEAT_W-1:0] bpb_l_q,    bpb_l_d;
    logic [SUB_W-1:0]  sub_l_q,    sub_l_d;
    logic [DC_W-1:0]   div_cnt_q,  div_cnt_d;
    logic [SUB_W-1:0]  rem_q,      rem_d;
    // Holds the shifting dividend during DIV and the clamped ticks-per-sub result in RUN.
    logic [CNT_W-1:0]  quo_q,      quo_d;
    logic [CNT_W-1:0]  bc_q,       bc_d;
    logic [CNT_W-1:0]  sc_q,       sc_d;
    logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
    logic [SUB_W-1:0]  sub_idx_q,  sub_idx_d;
    logic              beat_q,     beat_d;
    logic              accent_q,   accent_d;
    logic              sub_q,      sub_d;
    logic              busy_q,     busy_d;

    logic [SUB_W:0]    rem_shift;
    logic [SUB_W:0]    rem_diff;
    logic              rem_ge;
    logic [CNT_W-1:0]  quo_shift;
    logic [CNT_W-1:0]  bc_inc;
    logic [CNT_W-1:0]  sc_inc;
    logic              bc_wrap;
    logic              bar_wrap;
    logic              tick_hit;
    logic              start;

    // Datapath helpers: one restoring-divide step plus counter wrap/tick detection.
    always_comb begin
        rem_shift = {rem_q, quo_q[CNT_W-1]};
        rem_ge    = (rem_shift >= {1'b0, sub_l_q});
        rem_diff  = rem_shift - {1'b0, sub_l_q};
        quo_shift = {quo_q[CNT_W-2:0], rem_ge};
        bc_inc    = bc_q + CNT_W'(1);
        sc_inc    = sc_q + CNT_W'(1);
        bc_wrap   = (bc_q == period_l_q - CNT_W'(1));
        bar_wrap  = (beat_idx_q == bpb_l_q - BEAT_W'(1));
        // The last tick of a beat never fires early; it soaks up the division remainder.
        tick_hit  = (sc_inc == quo_q) && (sub_idx_q < sub_l_q - SUB_W'(1));
        // Reload always restarts; otherwise only a fresh enable edge leaves IDLE.
        start     = bus.i_reload || ((state_q == ST_IDLE) && !en_prev_q);
    end

    // Next-state and registered-output logic; enable-low beats reload, reload beats sync.
    always_comb begin
        state_d    = state_q;
        en_prev_d  = bus.i_enable;
        period_l_d = period_l_q;
        bpb_l_d    = bpb_l_q;
        sub_l_d    = sub_l_q;
        div_cnt_d  = div_cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        bc_d       = bc_q;
        sc_d       = sc_q;
        beat_idx_d = beat_idx_q;
        sub_idx_d  = sub_idx_q;
        beat_d     = 1'b0;
        accent_d   = 1'b0;
        sub_d      = 1'b0;
        busy_d     = 1'b0;

        if (!bus.i_enable) begin
            state_d    = ST_IDLE;
            bc_d       = '0;
            sc_d       = '0;
            beat_idx_d = '0;
            sub_idx_d  = '0;
        end else if (start) begin
            // Latch settings once; zero settings are treated as 1.
            state_d    = ST_DIV;
            period_l_d = (bus.i_period == '0) ? CNT_W'(1) : bus.i_period;
            bpb_l_d    = (bus.i_beats_per_bar == '0) ? BEAT_W'(1) : bus.i_beats_per_bar;
            sub_l_d    = (bus.i_subdiv == '0) ? SUB_W'(1) : bus.i_subdiv;
            quo_d      = (bus.i_period == '0) ? CNT_W'(1) : bus.i_period;
            rem_d      = '0;
            div_cnt_d  = '0;
            bc_d       = '0;
            sc_d       = '0;
            beat_idx_d = '0;
            sub_idx_d  = '0;
            busy_d     = 1'b1;
        end else begin
            case (state_q)
                ST_DIV: begin
                    rem_d = SUB_W'(rem_ge ? rem_diff : rem_shift);
                    if (div_cnt_q == DIV_LAST) begin
                        // Divide finished: enter RUN with a full beat/accent/sub pulse.
                        state_d    = ST_RUN;
                        quo_d      = (quo_shift == '0) ? CNT_W'(1) : quo_shift;
                        bc_d       = '0;
                        sc_d       = '0;
                        beat_idx_d = '0;
                        sub_idx_d  = '0;
                        beat_d     = 1'b1;
                        accent_d   = 1'b1;
                        sub_d      = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + DC_W'(1);
                        quo_d     = quo_shift;
                        busy_d    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.i_sync) begin
                        bc_d       = '0;
                        sc_d       = '0;
                        beat_idx_d = '0;
                        sub_idx_d  = '0;
                        beat_d     = 1'b1;
                        accent_d   = 1'b1;
                        sub_d      = 1'b1;
                    end else if (bc_wrap) begin
                        // Beat boundary takes precedence over any pending sub tick.
                        bc_d       = '0;
                        sc_d       = '0;
                        sub_idx_d  = '0;
                        beat_idx_d = bar_wrap ? '0 : beat_idx_q + BEAT_W'(1);
                        beat_d     = 1'b1;
                        sub_d      = 1'b1;
                        accent_d   = bar_wrap;
                    end else if (tick_hit) begin
                        bc_d      = bc_inc;
                        sc_d      = '0;
                        sub_idx_d = sub_idx_q + SUB_W'(1);
                        sub_d     = 1'b1;
                    end else begin
                        bc_d = bc_inc;
                        sc_d = sc_inc;
                    end
                end
                default: begin
                    bc_d       = '0;
                    sc_d       = '0;
                    beat_idx_d = '0;
                    sub_idx_d  = '0;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            en_prev_q  <= 1'b0;
            period_l_q <= CNT_W'(1);
            bpb_l_q    <= BEAT_W'(1);
            sub_l_q    <= SUB_W'(1);
            div_cnt_q  <= '0;
            rem_q      <= '0;
            quo_q      <= CNT_W'(1);
            bc_q       <= '0;
            sc_q       <= '0;
            beat_idx_q <= '0;
            sub_idx_q  <= '0;
            beat_q     <= 1'b0;
            accent_q   <= 1'b0;
            sub_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_prev_q  <= en_prev_d;
            period_l_q <= period_l_d;
            bpb_l_q    <= bpb_l_d;
            sub_l_q    <= sub_l_d;
            div_cnt_q  <= div_cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            bc_q       <= bc_d;
            sc_q       <= sc_d;
            beat_idx_q <= beat_idx_d;
            sub_idx_q  <= sub_idx_d;
            beat_q     <= beat_d;
            accent_q   <= accent_d;
            sub_q      <= sub_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_beat     = beat_q;
    assign bus.o_accent   = accent_q;
    assign bus.o_sub      = sub_q;
    assign bus.o_beat_idx = beat_idx_q;
    assign bus.o_sub_idx  = sub_idx_q;
    assign bus.o_busy     = busy_q;
endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Parametrised metronome beat engine for the successor of the single-trigger tempo path. Given a beat period in clock cycles from the tempo counter, it emits beat pulses, a bar-accent pulse on the first beat of every bar, and evenly spaced subdivision pulses within each beat. Its outputs drive the click/LED sound generators. It replaces the fixed single trigger with configurable time signature and subdivision.

## Interface
- CNT_W, 34: width of the beat period and cycle counters
- BEAT_W, 4: width of the beats-per-bar input and beat index (max 2^BEAT_W-1 beats)
- SUB_W, 3: width of the subdivision input and sub index (max 2^SUB_W-1 ticks per beat)
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  run when high; low forces IDLE
- i_reload  in  1  one-cycle pulse; relatch all settings and restart the bar (driven from the tempo-changed pulse)
- i_sync  in  1  one-cycle pulse; restart the bar at beat 0 without relatching
- i_period  in  CNT_W  clock cycles per beat
- i_beats_per_bar  in  BEAT_W  beats per bar
- i_subdiv  in  SUB_W  subdivision ticks per beat
- o_beat  out  1  one-cycle pulse at each beat
- o_accent  out  1  one-cycle pulse coincident with o_beat when beat index is 0
- o_sub  out  1  one-cycle pulse at each subdivision tick; also high on beats
- o_beat_idx  out  BEAT_W  current beat in bar
- o_sub_idx  out  SUB_W  current tick in beat
- o_busy  out  1  high during IDLE→RUN setup and divide

## Operation
- States: IDLE, DIV, RUN. All outputs are registered.
- Reset: state IDLE. All outputs are 0.
- IDLE: pulses, indices, and o_busy are 0. A rising i_enable, or i_reload while i_enable is high, enters DIV.
- Entry to DIV latches period_l = i_period, bpb_l = i_beats_per_bar, and sub_l = i_subdiv. Zero values are clamped to 1.
- DIV: restoring divider, one quotient bit per cycle, exactly CNT_W cycles. It computes sub_per = floor(period_l / sub_l), clamped to a minimum of 1. o_busy is high and pulses are low.
- RUN, first cycle: o_beat, o_accent, and o_sub are high. o_beat_idx and o_sub_idx are 0.
- Beat counter bc counts 0..period_l-1 and wraps. Each wrap produces o_beat and o_sub, resets sub_idx to 0, and advances beat_idx modulo bpb_l. o_accent is high when the new beat_idx is 0.
- Sub counter sc resets on each beat. When sc reaches sub_per and sub_idx < sub_l-1, emit o_sub, increment sub_idx, and set sc to 0.
- The remainder (period_l - sub_l*sub_per) is absorbed by the last tick. The beat boundary always wins, so subdivision ticks never delay a beat.
- i_sync in RUN: the next cycle is a beat/accent/sub pulse with both indices at 0. The counters restart, and latched settings are unchanged.
- Input changes without i_reload are ignored until the next reload or enable edge.
- Priority, high to low: reset, i_enable low, i_reload, i_sync. i_reload in DIV restarts the divide with newly latched values.

## Timing
- If i_reload is sampled high at edge t, o_busy is high for cycles t+1..t+CNT_W. The first o_beat is high in cycle t+CNT_W+1.
- Successive o_beat pulses are exactly period_l cycles apart; period_l=1 gives o_beat every cycle.
- Subdivision ticks fall at offsets k*sub_per, for k = 0..sub_l-1, from each beat.
- i_enable low at edge t: all outputs are 0 from cycle t+1.
- Asynchronous reset mid-RUN or mid-DIV forces all outputs to 0 immediately. After release, the block waits for an enable edge or a reload.

## Test plan
- CNT_W=16; enable, reload with period=100, bpb=4, subdiv=4. Required: o_busy for 16 cycles, then o_beat at cycle offsets 0,100,200,…; o_sub at 0,25,50,75,100,…; o_accent at 0,400,800; beat_idx sequence 0,1,2,3,0.
- period=10, subdiv=3. Required: sub_per=3; o_sub at offsets 0,3,6,10,13,16,20; the last tick in each beat lasts 4 cycles.
- period=2, subdiv=5. Required: sub_per clamped to 1; o_sub at offsets 0,1 of each beat only; sub_idx never exceeds 1.
- Assert i_sync mid-bar at beat_idx=2, cycle 37 of the beat. Required: the next cycle has o_beat and o_accent with indices 0, and the following beat comes 100 cycles later.
- Reload during DIV, then reload during RUN with period=50. Required: each reload restarts a full 16-cycle divide; the first beat is 17 cycles after the last reload; subsequent beats are 50 cycles apart.
- bpb=0, subdiv=0, period=0 → all clamped to 1: o_beat, o_accent, and o_sub high every cycle. Then drop i_reset_n mid-RUN: all outputs are 0 asynchronously.
